// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory-side signals of the shared memory port arbiter
// master is the arbiter's view, slave is the core/memory view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_gnt;
   logic              dm_rvalid;
   logic [DATA_W-1:0] dm_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   modport master (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport slave (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for instruction fetch and data load/store
// Optional round-robin arbitration under MEM_ARB_RR_EN; default is fixed priority, data over fetch.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 1
) (
   input  logic               clk,
   input  logic               reset,
   mem_port_arbiter_if.master bus
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   localparam logic [3:0] LAT = 4'(MEM_LATENCY);

   state_t            state;
   state_t            state_nxt;
   logic [3:0]        cnt;
   logic              owner;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_q;
   logic              if_rvalid_q;
   logic              dm_rvalid_q;

   logic              pick_dm;
   logic              grant;
   logic              last_done;
   logic              if_gnt_c;
   logic              dm_gnt_c;
   logic              mem_en_c;
   logic              mem_we_c;
   logic              busy_c;

`ifdef MEM_ARB_RR_EN
   logic              last_winner;

   // On a tie the port that did not win last time goes first; a lone request always wins.
   assign pick_dm = bus.dm_req && (!bus.if_req || !last_winner);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_winner <= 1'b0;
      end else if (grant) begin
         last_winner <= pick_dm;
      end
   end
`else
   assign pick_dm = bus.dm_req;
`endif

   // Grants are gated by reset so nothing is accepted that could not be latched.
   assign grant     = reset && (state == S_IDLE) && (bus.if_req || bus.dm_req);
   assign last_done = (state == S_WAIT) && (cnt == 4'd1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (grant) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  if (cnt == 4'd1) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      if_gnt_c = 1'b0;
      dm_gnt_c = 1'b0;
      mem_en_c = 1'b0;
      mem_we_c = 1'b0;
      busy_c   = (state != S_IDLE);
      if (grant) begin
         dm_gnt_c = pick_dm;
         if_gnt_c = !pick_dm;
      end
      if (state == S_ISSUE) begin
         mem_en_c = 1'b1;
         mem_we_c = we_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt         <= 4'd0;
         owner       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_rvalid_q <= 1'b0;
         dm_rvalid_q <= 1'b0;
      end else begin
         if_rvalid_q <= 1'b0;
         dm_rvalid_q <= 1'b0;
         if (grant) begin
            owner   <= pick_dm;
            we_q    <= pick_dm && bus.dm_we;
            addr_q  <= pick_dm ? bus.dm_addr : bus.if_addr;
            wdata_q <= bus.dm_wdata;
         end
         if (state == S_ISSUE) begin
            cnt <= LAT;
         end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
         end
         // Completion: stores leave the data register untouched, only the pulse is raised.
         if (last_done) begin
            if (owner) begin
               dm_rvalid_q <= 1'b1;
               if (!we_q) dm_rdata_q <= bus.mem_rdata;
            end else begin
               if_rvalid_q <= 1'b1;
               if_rdata_q  <= bus.mem_rdata;
            end
         end
      end
   end

   assign bus.if_gnt    = if_gnt_c;
   assign bus.dm_gnt    = dm_gnt_c;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.dm_rvalid = dm_rvalid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.mem_en    = mem_en_c;
   assign bus.mem_we    = mem_we_c;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.busy      = busy_c;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter (latency 1 and 4 instances)
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic reset1;
   logic reset4;
   int   n_total = 0;
   int   n_pass  = 0;

   logic [31:0] q_if1[$];
   logic [31:0] q_dm1[$];
   logic [31:0] q_if4[$];
   logic [31:0] q_dm4[$];
   logic [31:0] last_dm1;
   logic [31:0] p4 [4];
   logic        exp_dm;
   int          waitc;
`ifdef MEM_ARB_RR_EN
   logic        lw_dm;
`endif

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b4 ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) d1 (
      .clk(clk), .reset(reset1), .bus(b1.master)
   );
   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(4)) d4 (
      .clk(clk), .reset(reset4), .bus(b4.master)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h8) return 32'h0010_0193;
      return {a[15:0] ^ 16'hA5A5, a[15:0] ^ 16'h1234};
   endfunction

   // Read data is valid only in the cycle exactly MEM_LATENCY after mem_en.
   always @(posedge clk)
      b1.mem_rdata <= (b1.mem_en && !b1.mem_we) ? mem_word(b1.mem_addr) : 32'hBAD0_0001;

   always @(posedge clk) begin
      p4[0] <= (b4.mem_en && !b4.mem_we) ? mem_word(b4.mem_addr) : 32'hBAD0_0004;
      for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
   end
   assign b4.mem_rdata = p4[3];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (b1.if_rvalid) begin
         if (q_if1.size() == 0) check("if1_unexpected_rvalid", 1, 0);
         else check("if1_rdata", b1.if_rdata, q_if1.pop_front());
      end
      if (b1.dm_rvalid) begin
         if (q_dm1.size() == 0) check("dm1_unexpected_rvalid", 1, 0);
         else check("dm1_rdata", b1.dm_rdata, q_dm1.pop_front());
      end
      if (b4.if_rvalid) begin
         if (q_if4.size() == 0) check("if4_unexpected_rvalid", 1, 0);
         else check("if4_rdata", b4.if_rdata, q_if4.pop_front());
      end
      if (b4.dm_rvalid) begin
         if (q_dm4.size() == 0) check("dm4_unexpected_rvalid", 1, 0);
         else check("dm4_rdata", b4.dm_rdata, q_dm4.pop_front());
      end
   end

   task automatic acc1(input bit is_dm, input bit we, input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] e;
      if (is_dm) begin
         b1.dm_req = 1'b1; b1.dm_we = we; b1.dm_addr = a; b1.dm_wdata = wd;
         e = we ? last_dm1 : mem_word(a);
         q_dm1.push_back(e);
         last_dm1 = e;
      end else begin
         b1.if_req = 1'b1; b1.if_addr = a;
         q_if1.push_back(mem_word(a));
      end
      @(negedge clk);
      check("acc_gnt_winner", is_dm ? b1.dm_gnt : b1.if_gnt, 1);
      check("acc_gnt_other", is_dm ? b1.if_gnt : b1.dm_gnt, 0);
      tick();
      b1.if_req = 1'b0; b1.dm_req = 1'b0;
      @(negedge clk);
      check("acc_issue_en", b1.mem_en, 1);
      check("acc_issue_we", b1.mem_we, we);
      check("acc_issue_addr", b1.mem_addr, a);
      if (we) check("acc_issue_wdata", b1.mem_wdata, wd);
      tick();
      @(negedge clk);
      check("acc_wait_en", b1.mem_en, 0);
      check("acc_wait_rvalid", is_dm ? b1.dm_rvalid : b1.if_rvalid, 0);
      tick();
      @(negedge clk);
      check("acc_rvalid", is_dm ? b1.dm_rvalid : b1.if_rvalid, 1);
      check("acc_busy_done", b1.busy, 0);
   endtask

   initial begin
      reset1 = 1'b0; reset4 = 1'b0; last_dm1 = 32'h0;
      b1.if_req = 0; b1.if_addr = 0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_addr = 0; b1.dm_wdata = 0;
      b4.if_req = 0; b4.if_addr = 0; b4.dm_req = 0; b4.dm_we = 0; b4.dm_addr = 0; b4.dm_wdata = 0;
      tick(); tick();
      @(negedge clk);
      check("rst_busy", b1.busy, 0);
      check("rst_mem_en", b1.mem_en, 0);
      check("rst_gnt", {b1.if_gnt, b1.dm_gnt}, 0);
      check("rst_rvalid", {b1.if_rvalid, b1.dm_rvalid}, 0);
      check("rst_if_rdata", b1.if_rdata, 0);
      check("rst_dm_rdata", b1.dm_rdata, 0);
      tick();
      reset1 = 1'b1; reset4 = 1'b1;

      tick(); acc1(1'b1, 1'b0, 32'h20, 32'h0);
      tick(); acc1(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
      tick(); acc1(1'b0, 1'b0, 32'h08, 32'h0);

      // Simultaneous requests after a fetch: data wins in either arbitration mode.
      tick();
      b1.if_req = 1; b1.if_addr = 32'h0C; b1.dm_req = 1; b1.dm_we = 0; b1.dm_addr = 32'h10;
      q_dm1.push_back(mem_word(32'h10)); last_dm1 = mem_word(32'h10);
      q_if1.push_back(mem_word(32'h0C));
      @(negedge clk);
      check("sim_dm_gnt", b1.dm_gnt, 1);
      check("sim_if_gnt_blocked", b1.if_gnt, 0);
      tick(); b1.dm_req = 0;
      @(negedge clk);
      check("sim_if_gnt_issue", b1.if_gnt, 0);
      check("sim_issue_addr", b1.mem_addr, 32'h10);
      tick(); @(negedge clk);
      check("sim_if_gnt_wait", b1.if_gnt, 0);
      tick(); @(negedge clk);
      check("sim_dm_rvalid", b1.dm_rvalid, 1);
      check("sim_if_gnt_t3", b1.if_gnt, 1);
      tick(); b1.if_req = 0;
      @(negedge clk);
      check("sim_if_issue_addr", b1.mem_addr, 32'h0C);
      tick(); tick(); @(negedge clk);
      check("sim_if_rvalid_t6", b1.if_rvalid, 1);

      // Both requests held: grant sequence depends on arbitration mode.
      tick();
      b1.if_req = 1; b1.if_addr = 32'h0C; b1.dm_req = 1; b1.dm_we = 0; b1.dm_addr = 32'h10;
`ifdef MEM_ARB_RR_EN
      lw_dm = 1'b0;
`endif
      for (int g = 0; g < 4; g++) begin
         waitc = 0;
         @(negedge clk);
         while (!(b1.if_gnt || b1.dm_gnt) && waitc < 10) begin
            tick(); @(negedge clk); waitc++;
         end
         if (waitc >= 10) begin
            check("hold_grant_timeout", 0, 1);
         end else begin
`ifdef MEM_ARB_RR_EN
            exp_dm = !lw_dm; lw_dm = exp_dm;
`else
            exp_dm = 1'b1;
`endif
            check("hold_dm_gnt", b1.dm_gnt, exp_dm);
            check("hold_if_gnt", b1.if_gnt, !exp_dm);
            if (exp_dm) begin
               q_dm1.push_back(mem_word(32'h10)); last_dm1 = mem_word(32'h10);
            end else begin
               q_if1.push_back(mem_word(32'h0C));
            end
         end
         tick();
         if (g == 3) begin b1.if_req = 0; b1.dm_req = 0; end
      end
      repeat (4) tick();

      // Latency-4 instance: abort a load in its second WAIT cycle.
      b4.dm_req = 1; b4.dm_we = 0; b4.dm_addr = 32'h30;
      @(negedge clk);
      check("l4_dm_gnt", b4.dm_gnt, 1);
      tick(); b4.dm_req = 0;
      tick(); tick();
      reset4 = 1'b0; b4.if_req = 1; b4.if_addr = 32'h14;
      #1;
      check("l4_abort_busy", b4.busy, 0);
      check("l4_abort_mem_en", b4.mem_en, 0);
      @(negedge clk);
      check("l4_gnt_in_reset", b4.if_gnt, 0);
      tick();
      reset4 = 1'b1;
      @(negedge clk);
      check("l4_if_gnt_after_release", b4.if_gnt, 1);
      q_if4.push_back(mem_word(32'h14));
      tick(); b4.if_req = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         check("l4_if_rvalid_timing", b4.if_rvalid, (k == 6) ? 1'b0 : 1'b0);
         tick();
         if (k == 5) begin
            @(negedge clk);
            check("l4_if_rvalid_t6", b4.if_rvalid, 1);
            check("l4_dm_rvalid_none", b4.dm_rvalid, 0);
            break;
         end
      end

      // Reset during ISSUE on the latency-1 instance clears everything immediately.
      tick();
      b1.if_req = 1; b1.if_addr = 32'h04;
      @(negedge clk);
      check("mr_if_gnt", b1.if_gnt, 1);
      tick(); b1.if_req = 0;
      @(negedge clk);
      check("mr_issue_en", b1.mem_en, 1);
      #2 reset1 = 1'b0;
      #1;
      check("mr_mem_en_async", b1.mem_en, 0);
      check("mr_mem_we", b1.mem_we, 0);
      check("mr_mem_addr", b1.mem_addr, 0);
      check("mr_busy", b1.busy, 0);
      check("mr_gnt", {b1.if_gnt, b1.dm_gnt}, 0);
      check("mr_rvalid", {b1.if_rvalid, b1.dm_rvalid}, 0);
      check("mr_if_rdata", b1.if_rdata, 0);
      check("mr_dm_rdata", b1.dm_rdata, 0);
      tick();
      reset1 = 1'b1; last_dm1 = 32'h0;
      repeat (5) tick();

      check("q_if1_drained", q_if1.size(), 0);
      check("q_dm1_drained", q_dm1.size(), 0);
      check("q_if4_drained", q_if4.size(), 0);
      check("q_dm4_drained", q_dm4.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
